// File: rtl/cpu_mem_responder.sv
// cpu_mem_responder
//   Responder for the CPU's instruction-fetch and data load/store ports.
//   Both ports are arbitrated onto one shared downstream memory port. Each
//   port's completion (resp + read data) is held until the pipeline advances,
//   so both resps can be high in the same cycle.
//
// Optional feature macro: CPU_MEM_RESPONDER_PERF_EN (adds perf_* counters).
//
// Ports:
//   clk, rst (async, active low), advance (clears held completions)
//   inst_mem_read/addr -> inst_mem_resp/rdata      instruction port
//   data_mem_read/write/addr/wdata/mbe -> data_mem_resp/rdata   data port
//   mem_read/write/addr/wdata/mbe, mem_resp/rdata  shared downstream port
//   perf_inst_cnt/perf_data_cnt/perf_wait_cnt      (only with the macro)
module cpu_mem_responder #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                advance,
   input  logic                inst_mem_read,
   input  logic [ADDR_W-1:0]   inst_mem_addr,
   output logic                inst_mem_resp,
   output logic [DATA_W-1:0]   inst_mem_rdata,
   input  logic                data_mem_read,
   input  logic                data_mem_write,
   input  logic [ADDR_W-1:0]   data_mem_addr,
   input  logic [DATA_W-1:0]   data_mem_wdata,
   input  logic [DATA_W/8-1:0] data_mem_mbe,
   output logic                data_mem_resp,
   output logic [DATA_W-1:0]   data_mem_rdata,
   output logic                mem_read,
   output logic                mem_write,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_wdata,
   output logic [DATA_W/8-1:0] mem_mbe,
   input  logic                mem_resp,
   input  logic [DATA_W-1:0]   mem_rdata
`ifdef CPU_MEM_RESPONDER_PERF_EN
   ,
   output logic [31:0]         perf_inst_cnt,
   output logic [31:0]         perf_data_cnt,
   output logic [31:0]         perf_wait_cnt
`endif
);

   typedef enum logic [1:0] {IDLE, SERVE_D, SERVE_I} state_t;

   state_t state, state_nxt;
   logic   done_i, done_d;
   logic   data_req, pend_i, pend_d;
   logic   fin_i, fin_d;

   // a port is pending only while it has no held completion (sticky done)
   always_comb begin
      data_req = data_mem_read | data_mem_write;
      pend_d   = data_req & ~done_d;
      pend_i   = inst_mem_read & ~done_i;
      // completion only counts if the requester is still asking; a request
      // dropped mid-service lets the downstream finish but discards the result
      fin_d    = (state == SERVE_D) & mem_resp & data_req;
      fin_i    = (state == SERVE_I) & mem_resp & inst_mem_read;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   // data first: it belongs to the older instruction in the pipeline
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (pend_d)      state_nxt = SERVE_D;
            else if (pend_i) state_nxt = SERVE_I;
         end
         SERVE_D, SERVE_I: if (mem_resp) state_nxt = IDLE;
         default:          state_nxt = IDLE;
      endcase
   end

   // downstream request register; fields are stable for the whole service
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mem_read  <= 1'b0;
         mem_write <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_mbe   <= '0;
      end else if (state == IDLE) begin
         if (pend_d) begin
            // read+write together is a protocol error; treated as a write
            mem_read  <= ~data_mem_write;
            mem_write <= data_mem_write;
            mem_addr  <= data_mem_addr;
            mem_wdata <= data_mem_wdata;
            mem_mbe   <= data_mem_mbe;
         end else if (pend_i) begin
            mem_read  <= 1'b1;
            mem_write <= 1'b0;
            mem_addr  <= inst_mem_addr;
            mem_mbe   <= '0;
         end
      end else if (mem_resp) begin
         mem_read  <= 1'b0;
         mem_write <= 1'b0;
      end
   end

   // held completions; a same-cycle completion beats advance
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         done_i         <= 1'b0;
         done_d         <= 1'b0;
         inst_mem_rdata <= '0;
         data_mem_rdata <= '0;
      end else begin
         done_i <= (done_i & ~advance) | fin_i;
         done_d <= (done_d & ~advance) | fin_d;
         if (fin_i)            inst_mem_rdata <= mem_rdata;
         if (fin_d && mem_read) data_mem_rdata <= mem_rdata;
      end
   end

   assign inst_mem_resp = done_i & inst_mem_read;
   assign data_mem_resp = done_d & data_req;

`ifdef CPU_MEM_RESPONDER_PERF_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         perf_inst_cnt <= '0;
         perf_data_cnt <= '0;
         perf_wait_cnt <= '0;
      end else begin
         if (fin_i) perf_inst_cnt <= perf_inst_cnt + 32'd1;
         if (fin_d) perf_data_cnt <= perf_data_cnt + 32'd1;
         if (pend_i || pend_d || state != IDLE)
            perf_wait_cnt <= perf_wait_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: doc/cpu_mem_responder.md
Name: cpu_mem_responder

Overview:
- Responder side of the CPU's two memory request ports: instruction fetch and data load/store.
- Arbitrates both ports onto one shared downstream memory port.
- Holds each port's completion (resp plus read data) until the pipeline advances, so both resps can be high together.
- Sits between the CPU datapath/control and the shared cache/physical memory.

Parameters:
ADDR_W, 32, request address width
DATA_W, 32, data word width; mask width is DATA_W/8

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
advance  in  1  pipeline-advance pulse (buffer load); consumes held completions
inst_mem_read  in  1  instruction read request (level)
inst_mem_addr  in  ADDR_W  instruction address
inst_mem_resp  out  1  instruction completion held
inst_mem_rdata  out  DATA_W  instruction word
data_mem_read  in  1  data read request (level)
data_mem_write  in  1  data write request (level)
data_mem_addr  in  ADDR_W  data address
data_mem_wdata  in  DATA_W  store data
data_mem_mbe  in  DATA_W/8  store byte enables
data_mem_resp  out  1  data completion held
data_mem_rdata  out  DATA_W  load data
mem_read  out  1  downstream read
mem_write  out  1  downstream write
mem_addr  out  ADDR_W  downstream address
mem_wdata  out  DATA_W  downstream store data
mem_mbe  out  DATA_W/8  downstream byte enables
mem_resp  in  1  downstream completion, single-cycle
mem_rdata  in  DATA_W  downstream read data, valid with mem_resp

Behaviour:
- Reset (rst=0, async): state IDLE; all mem_* outputs 0; both done flags 0; both rdata registers 0; both resps 0.
- FSM states:
  - IDLE: a port is pending when its request is high and its done flag is 0.
    - If data is pending, latch addr/wdata/mbe/op and go to SERVE_D. Data has priority because it belongs to the older instruction.
    - Otherwise, if inst is pending, latch the address and go to SERVE_I.
    - Otherwise stay in IDLE.
  - SERVE_D / SERVE_I: registered mem_read or mem_write held high with the latched fields, stable until mem_resp.
    - On mem_resp, drop mem_read/mem_write on the next edge, capture mem_rdata (reads only), set the port's done flag and go to IDLE.
- data_mem_read and data_mem_write both high: a protocol error; treat as a write.
- Request inputs are never passed combinationally downstream. mem_* is registered.
- Latency:
  - The downstream request appears 1 cycle after a pending request is seen in IDLE.
  - The port's resp rises 1 cycle after mem_resp.
  - Minimum inst round trip with 1-cycle memory: 3 cycles.
- Outputs:
  - x_mem_resp = done_x AND (request of x still high); combinational gate on the registered flag.
  - x_mem_rdata is held from the capture register until the next capture.
- Completions are sticky: a done port is not re-serviced, even with its request still high, until advance clears the flag.
- advance clears both done flags on the clock edge.
  - If mem_resp completes port x in the same cycle, done_x is set (set wins).
- Request dropped during its own service: the downstream transaction runs to completion (no abort); its data is discarded and done is not set.
- New pending request arriving while the other port is being served: served from IDLE after the current transaction. No preemption.
- Async reset mid-transaction: mem_read/mem_write drop immediately. The downstream must be reset in the same domain; the outstanding response is not tracked.

Optional Feature:
- Macro: CPU_MEM_RESPONDER_PERF_EN.
- Defined: adds 32-bit registered output counters.
  - perf_inst_cnt: completed inst transactions.
  - perf_data_cnt: completed data transactions.
  - perf_wait_cnt: cycles where any port is pending or in service while done is 0.
  - All counters reset to 0 and wrap at 2^32.
- Undefined: no counters, no perf ports; logic is otherwise identical.

Test Plan:
- Inst only: inst_mem_read=1, addr=0x60; mem_resp 2 cycles after mem_read with rdata=0x00000013.
  - Required: mem_addr=0x60; inst_mem_resp rises 1 cycle after mem_resp and holds with rdata=0x13 until advance.
  - After advance, a new request at 0x64 is serviced.
- Both ports raised together (inst 0x64; data read 0x1000 returns 0xDEADBEEF).
  - Required: data served first, then inst.
  - Both resps are high simultaneously once inst completes; advance clears both in one edge.
- Store: data_mem_write=1, addr=0x2004, wdata=0xA5A5A5A5, mbe=4'b0011.
  - Required: mem_write with identical fields; data_mem_resp held; data_mem_rdata unchanged.
- advance coincident with mem_resp for inst.
  - Required: inst done set (set wins); data done cleared.
- Inst request dropped mid-service.
  - Required: downstream read completes; inst_mem_resp stays 0; FSM returns to IDLE.
- rst pulled low during SERVE_D.
  - Required: mem_read=0 immediately; resps=0; after release, a pending request is re-issued from IDLE.
